// File: rtl/dsc_stoch2bin_rx.sv
// Framed stochastic-to-binary decoder: counts ones over 2^LOG_LEN enabled bits and
// publishes each frame's count through a valid/ready register. Option: DSC_S2B_SATURATE_EN.
module dsc_stoch2bin_rx #(
  parameter int unsigned LOG_LEN = 12,
`ifdef DSC_S2B_SATURATE_EN
  localparam int unsigned ZW = LOG_LEN
`else
  localparam int unsigned ZW = LOG_LEN + 1
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          sync,
  input  logic          sn_in,
  output logic [ZW-1:0] z,
  output logic          z_valid,
  input  logic          z_ready,
  output logic          frame_done,
  output logic          ovr
);

  localparam int unsigned PW = LOG_LEN;
  localparam int unsigned CW = LOG_LEN + 1;
  localparam logic [PW-1:0] POS_MAX = '1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [CW-1:0] ones_q, ones_d;
  logic [ZW-1:0] z_q, z_d;
  logic          frame_done_q, frame_done_d;
  logic          ovr_q, ovr_d;

  logic [CW-1:0] sum_c;
  logic [ZW-1:0] res_c;
  logic          done_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      pos_q        <= '0;
      ones_q       <= '0;
      z_q          <= '0;
      frame_done_q <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      ones_q       <= ones_d;
      z_q          <= z_d;
      frame_done_q <= frame_done_d;
      ovr_q        <= ovr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    ones_d       = ones_q;
    z_d          = z_q;
    frame_done_d = 1'b0;
    ovr_d        = ovr_q;

    sum_c  = ones_q + CW'(sn_in);
    // sync outranks completion: a frame ending on a sync cycle is discarded
    done_c = en && !sync && (pos_q == POS_MAX);
`ifdef DSC_S2B_SATURATE_EN
    res_c  = sum_c[LOG_LEN] ? ZW'({ZW{1'b1}}) : ZW'(sum_c[LOG_LEN-1:0]);
`else
    res_c  = ZW'(sum_c);
`endif

    if (sync) begin
      pos_d  = en ? PW'(1) : '0;
      ones_d = en ? CW'(sn_in) : '0;
    end else if (en) begin
      if (done_c) begin
        pos_d  = '0;
        ones_d = '0;
      end else begin
        pos_d  = pos_q + PW'(1);
        ones_d = sum_c;
      end
    end

    frame_done_d = done_c;

    case (state_q)
      EMPTY: begin
        if (done_c) begin
          z_d     = res_c;
          state_d = FULL;
        end
      end
      FULL: begin
        if (done_c) begin
          if (z_ready) z_d = res_c;
          else ovr_d = 1'b1;
        end else if (z_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign z          = z_q;
  assign z_valid    = (state_q == FULL);
  assign frame_done = frame_done_q;
  assign ovr        = ovr_q;

endmodule

// File: tb/tb_dsc_stoch2bin_rx.sv
// Directed bench for dsc_stoch2bin_rx at LOG_LEN=4 (16-bit frames).
module tb_dsc_stoch2bin_rx;

  localparam int unsigned LOG_LEN = 4;
`ifdef DSC_S2B_SATURATE_EN
  localparam int unsigned ZW = LOG_LEN;
  localparam logic [31:0] FULL_CNT = 32'd15;
`else
  localparam int unsigned ZW = LOG_LEN + 1;
  localparam logic [31:0] FULL_CNT = 32'd16;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          sync;
  logic          sn_in;
  logic [ZW-1:0] z;
  logic          z_valid;
  logic          z_ready;
  logic          frame_done;
  logic          ovr;

  int checks   = 0;
  int failures = 0;

  dsc_stoch2bin_rx #(.LOG_LEN(LOG_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sync      (sync),
    .sn_in     (sn_in),
    .z         (z),
    .z_valid   (z_valid),
    .z_ready   (z_ready),
    .frame_done(frame_done),
    .ovr       (ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of input, then sample 1 time unit after the edge.
  task automatic step(input logic e, input logic s);
    en    = e;
    sn_in = s;
    @(posedge clk);
    #1;
  endtask

  // n enabled bits, the first n_ones of them set.
  task automatic run_bits(input int n, input int n_ones);
    for (int i = 0; i < n; i++) step(1'b1, i < n_ones);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sync = 1'b0; sn_in = 1'b0; z_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_z", 32'(z), 0);
    check("rst_valid", 32'(z_valid), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_ovr", 32'(ovr), 0);

    // All-ones frame
    z_ready = 1'b1;
    run_bits(15, 15);
    check("ones_early_done", 32'(frame_done), 0);
    check("ones_early_valid", 32'(z_valid), 0);
    step(1'b1, 1'b1);
    check("ones_z", 32'(z), FULL_CNT);
    check("ones_valid", 32'(z_valid), 1);
    check("ones_done", 32'(frame_done), 1);
    step(1'b0, 1'b0);
    check("ones_consumed", 32'(z_valid), 0);
    check("ones_done_pulse", 32'(frame_done), 0);
    check("ones_z_hold", 32'(z), FULL_CNT);

    // en toggling; sn_in=1 on disabled cycles must be ignored
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 1) step(1'b1, ((i - 1) / 2) % 2 == 0);
      else            step(1'b0, 1'b1);
      if (i == 30) check("alt_not_yet", 32'(frame_done), 0);
    end
    check("alt_z", 32'(z), 8);
    check("alt_done", 32'(frame_done), 1);

    // Back-to-back frames under back-pressure
    step(1'b0, 1'b0);
    check("bp_empty", 32'(z_valid), 0);
    z_ready = 1'b0;
    run_bits(16, 7);
    check("bp_z1", 32'(z), 7);
    check("bp_ovr1", 32'(ovr), 0);
    run_bits(16, 3);
    check("bp_done2", 32'(frame_done), 1);
    check("bp_z_held", 32'(z), 7);
    check("bp_valid", 32'(z_valid), 1);
    check("bp_ovr2", 32'(ovr), 1);
    z_ready = 1'b1;
    step(1'b0, 1'b0);
    check("bp_drain_valid", 32'(z_valid), 0);
    check("bp_ovr_sticky", 32'(ovr), 1);

    // Async reset mid-frame while FULL
    z_ready = 1'b0;
    run_bits(16, 16);
    run_bits(5, 5);
    check("pre_rst_valid", 32'(z_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_z", 32'(z), 0);
    check("arst_valid", 32'(z_valid), 0);
    check("arst_ovr", 32'(ovr), 0);
    check("arst_done", 32'(frame_done), 0);
    #1 rst = 1'b0;
    run_bits(15, 0);
    check("post_rst_early", 32'(frame_done), 0);
    step(1'b1, 1'b0);
    check("post_rst_z", 32'(z), 0);
    check("post_rst_valid", 32'(z_valid), 1);
    check("post_rst_done", 32'(frame_done), 1);

    // Accept exactly on completion while FULL
    z_ready = 1'b1;
    step(1'b0, 1'b0);
    z_ready = 1'b0;
    run_bits(16, 7);
    check("acc_z1", 32'(z), 7);
    run_bits(15, 3);
    z_ready = 1'b1;
    step(1'b1, 1'b0);
    check("acc_z2", 32'(z), 3);
    check("acc_valid", 32'(z_valid), 1);
    check("acc_ovr", 32'(ovr), 0);

    // sync discards partial frame and its bit starts the new one
    run_bits(9, 5);
    check("sync_pre_valid", 32'(z_valid), 0);
    sync = 1'b1;
    step(1'b1, 1'b1);
    sync = 1'b0;
    check("sync_no_done", 32'(frame_done), 0);
    run_bits(14, 0);
    check("sync_early", 32'(frame_done), 0);
    step(1'b1, 1'b0);
    check("sync_done", 32'(frame_done), 1);
    check("sync_z", 32'(z), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1);
  end

endmodule

// File: doc/dsc_stoch2bin_rx.md
# dsc_stoch2bin_rx

Framed stochastic-to-binary decoder: the receiving end of the serial deterministic-stochastic (DSC) bitstreams our SNG chains and DSC multipliers produce. It counts ones over a fixed frame of 2^LOG_LEN enabled cycles and publishes the count through a valid/ready output register. A sticky overrun flag records any result lost to back-pressure. It replaces the bare free-running counter at the output of the DSC datapaths wherever a downstream consumer must see framed results.

## Interface
Parameters:
- LOG_LEN, default 12, log2 of frame length; 12 = 3 inputs × 4-bit SNG.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  bit-valid; sn_in is sampled only on cycles where en=1.
- sync  in  1  synchronous frame restart; discards the partial frame.
- sn_in  in  1  stochastic bitstream input.
- z  out  LOG_LEN+1 (LOG_LEN with DSC_S2B_SATURATE_EN)  count of ones in the last completed frame.
- z_valid  out  1  z holds an unconsumed result.
- z_ready  in  1  consumer accepts z when z_valid & z_ready.
- frame_done  out  1  one-cycle pulse after each frame completes.
- ovr  out  1  sticky overrun: a completed result was dropped.

## Operation
- Internal state:
  - pos: LOG_LEN-bit position counter.
  - ones: LOG_LEN+1-bit accumulator.
  - Output FSM, EMPTY/FULL; z_valid = (state == FULL).
- On each en=1 cycle:
  - ones += sn_in.
  - pos increments; pos wraps from 2^LOG_LEN-1 to 0.
- Cycles with en=0 freeze pos and ones and do not count toward the frame.
- Frame completes when en=1 and pos = 2^LOG_LEN-1.
  - The final sum is ones + sn_in, range 0..2^LOG_LEN.
  - pos and ones restart at 0 on the same edge, so frames run back-to-back with no gap.
- sync=1:
  - pos and ones are cleared; no result is produced for the partial frame.
  - If en=1 on the same cycle, that bit is bit 0 of the new frame: pos=1, ones=sn_in.
  - sync has priority over frame completion on the same cycle.
- Output FSM:
  - EMPTY, frame completes → load z, go to FULL.
  - FULL, z_ready=1, no completion → go to EMPTY; z holds its value.
  - FULL, z_ready=1 and completion on the same cycle → load new z, stay FULL, ovr unchanged.
  - FULL, z_ready=0 and completion → new result dropped, z unchanged, ovr set.
- frame_done pulses on every completion, including dropped ones.
- ovr clears only on rst.
- Reset, including mid-frame: pos=0, ones=0, state EMPTY, z=0, z_valid=0, frame_done=0, ovr=0. Any partial frame is discarded.

## Timing
- Latency: z, z_valid and frame_done update on the same edge that samples the frame's final bit; no extra pipeline stage.
- z_valid is visible the cycle after the last bit is presented.
- Handshake is a consume-on-edge: z_valid deasserts on the edge where z_valid & z_ready is sampled.
- z is stable whenever z_valid=1 and no accepted completion occurs.
- Minimum frame period is 2^LOG_LEN cycles, with en held high.

## Configuration
- DSC_S2B_SATURATE_EN defined:
  - z is LOG_LEN bits wide.
  - A full-ones count of 2^LOG_LEN is clamped to 2^LOG_LEN-1, matching the unipolar [0,1) range of the SNG encoders.
- DSC_S2B_SATURATE_EN undefined:
  - z is LOG_LEN+1 bits wide.
  - The exact count is reported, so all-ones gives 2^LOG_LEN.

## Test plan
All scenarios use LOG_LEN=4 (16-bit frame).
- All-ones frame, en=1, z_ready=1 → after 16 cycles, z=16 (15 with DSC_S2B_SATURATE_EN), z_valid and frame_done for 1 cycle.
- Pattern 1010… with en toggling 1/0 every cycle → completes after 32 cycles with z=8. en=0 cycles ignored.
- Two back-to-back frames (7 ones, then 3), z_ready=0 throughout → z=7 held, ovr=1 after the second frame ends. Then z_ready=1 → z_valid drops next edge, ovr stays 1.
- z_ready=1 on the exact completion cycle of frame 2 while FULL → z updates to 3, z_valid stays 1, ovr=0.
- Frame sequence:
  - 5 ones in the first 9 bits, then sync with en=1, sn_in=1.
  - Then 15 more bits, all 0.
  - Expected: z=1; the partial frame is never reported.
- rst asserted asynchronously mid-frame and mid-FULL → all outputs 0 immediately. The next full frame of 16 zeros → z=0, z_valid=1.
